// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sharing one external ALU between two requesters
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] b1,
    input  logic [2:0]       op0,
    input  logic [2:0]       op1,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic [WIDTH-1:0] ReadData1,
    output logic [WIDTH-1:0] ReadData2,
    output logic [2:0]       ALUop,
    output logic             ALUSrcA,
    output logic             ALUSrcB,
    output logic [WIDTH-1:0] Ext,
    output logic [WIDTH-1:0] Sa,
    output logic             ack0,
    output logic             ack1,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t           state, state_nxt;
    logic             ptr, owner, grant, pick;
    logic [WIDTH-1:0] opa, opb;
    logic [2:0]       opc;

    // Grant only from IDLE; on contention the pointer names the winner
    always_comb begin
        pick = (req0 && req1) ? ptr : req1;
        grant = state == IDLE && (req0 || req1);
        state_nxt = state == EXEC ? RESP : state == RESP ? IDLE : grant ? EXEC : IDLE;
    end

    // State register, operand capture on grant, ALU result capture in EXEC
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            ptr    <= 1'b0;
            owner  <= 1'b0;
            opa    <= '0;
            opb    <= '0;
            opc    <= '0;
            result <= '0;
            zero   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                owner <= pick;
                ptr   <= ~pick;
                opa   <= pick ? a1 : a0;
                opb   <= pick ? b1 : b0;
                opc   <= pick ? op1 : op0;
            end
            if (state == EXEC) begin
                result <= alu_result;
                zero   <= alu_zero;
            end
        end
    end

    assign ReadData1 = opa;
    assign ReadData2 = opb;
    assign ALUop     = opc;
    assign ALUSrcA   = 1'b0;
    assign ALUSrcB   = 1'b0;
    assign Ext       = '0;
    assign Sa        = '0;
    assign ack0      = state == RESP && !owner;
    assign ack1      = state == RESP && owner;
    assign busy      = state != IDLE;
endmodule
